// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage (master) and the data memory (slave).
interface mem_stage_if #(
   parameter int DATA_W = 32
);
   logic              data_req;
   logic              data_wr;
   logic [3:0]        data_wstrb;
   logic [DATA_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [DATA_W-1:0] data_rdata;

   modport master (
      output data_req, data_wr, data_wstrb, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute bundle, runs the data-memory handshake,
// aligns load data and feeds write-back and forwarding. Define MEM_LOAD_FWD_EN to forward load data in the data_ok cycle.
module mem_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_to_mem_valid_i,
   output logic              mem_allowin_o,
   input  logic              excep_flush_i,
   input  logic [DATA_W-1:0] pc_i,
   input  logic              req_i,
   input  logic [3:0]        we_i,
   input  logic [DATA_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [2:0]        ld_type_i,
   input  logic              regs_we_i,
   input  logic [REG_AW-1:0] regs_waddr_i,
   input  logic [DATA_W-1:0] regs_wdata_i,
   input  logic              excep_en_i,
   mem_stage_if.master       dmem,
   input  logic              wb_allowin_i,
   output logic              mem_to_wb_valid_o,
   output logic [DATA_W-1:0] wb_pc_o,
   output logic              wb_regs_we_o,
   output logic [REG_AW-1:0] wb_regs_waddr_o,
   output logic [DATA_W-1:0] wb_regs_wdata_o,
   output logic              wb_excep_en_o,
   output logic              fwd_we_o,
   output logic [REG_AW-1:0] fwd_waddr_o,
   output logic [DATA_W-1:0] fwd_wdata_o,
   output logic              fwd_busy_o,
   output logic              mem_excep_o
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_e;
   typedef enum logic [2:0] {LD_W = 3'd0, LD_B = 3'd1, LD_BU = 3'd2, LD_H = 3'd3, LD_HU = 3'd4} ld_type_e;

   state_e            r_state;
   state_e            w_state_nxt;
   logic              r_valid;
   logic [DATA_W-1:0] r_pc;
   logic              r_req;
   logic [3:0]        r_we;
   logic [DATA_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   ld_type_e          r_ld_type;
   logic              r_regs_we;
   logic [REG_AW-1:0] r_regs_waddr;
   logic [DATA_W-1:0] r_regs_wdata;
   logic              r_excep_en;
   logic [DATA_W-1:0] r_result;

   logic              w_ready_go;
   logic              w_accept;
   logic              w_accept_mem;
   logic              w_handoff;
   logic              w_is_load;
   logic              w_resp_now;
   logic [DATA_W-1:0] w_shifted;
   logic [DATA_W-1:0] w_load_data;

   assign w_ready_go    = (r_state == S_IDLE) || (r_state == S_DONE);
   assign mem_allowin_o = !rst && (r_state != S_CANCEL) &&
                          (!r_valid || (w_ready_go && wb_allowin_i));
   assign w_accept      = ex_to_mem_valid_i && mem_allowin_o;
   assign w_accept_mem  = w_accept && req_i && !excep_en_i;
   // A flushing write-back stage must never see this instruction, even for one cycle.
   assign mem_to_wb_valid_o = r_valid && w_ready_go && !excep_flush_i;
   assign w_handoff     = mem_to_wb_valid_o && wb_allowin_i;
   assign w_is_load     = r_req && (r_we == 4'b0000) && !r_excep_en;
   assign w_resp_now    = (r_state == S_WAIT) && dmem.data_data_ok;

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (!excep_flush_i && w_accept_mem) w_state_nxt = S_REQ;
         S_REQ: begin
            if (excep_flush_i)          w_state_nxt = dmem.data_addr_ok ? S_CANCEL : S_IDLE;
            else if (dmem.data_addr_ok) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (excep_flush_i)          w_state_nxt = dmem.data_data_ok ? S_IDLE : S_CANCEL;
            else if (dmem.data_data_ok) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (excep_flush_i)     w_state_nxt = S_IDLE;
            else if (w_accept_mem) w_state_nxt = S_REQ;
            else if (w_handoff)    w_state_nxt = S_IDLE;
         end
         S_CANCEL: if (dmem.data_data_ok) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                r_valid <= 1'b0;
      else if (excep_flush_i) r_valid <= 1'b0;
      else if (w_accept)      r_valid <= 1'b1;
      else if (w_handoff)     r_valid <= 1'b0;
   end

   // NOTE: the payload is reset too, because it drives the wb_* and dmem outputs directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc         <= '0;
         r_req        <= 1'b0;
         r_we         <= 4'b0000;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_ld_type    <= LD_W;
         r_regs_we    <= 1'b0;
         r_regs_waddr <= '0;
         r_regs_wdata <= '0;
         r_excep_en   <= 1'b0;
      end else if (w_accept) begin
         r_pc         <= pc_i;
         r_req        <= req_i;
         r_we         <= we_i;
         r_addr       <= addr_i;
         r_wdata      <= wdata_i;
         r_ld_type    <= ld_type_e'(ld_type_i);
         r_regs_we    <= regs_we_i;
         r_regs_waddr <= regs_waddr_i;
         r_regs_wdata <= regs_wdata_i;
         r_excep_en   <= excep_en_i;
      end
   end

   assign w_shifted = dmem.data_rdata >> {r_addr[1:0], 3'b000};

   always_comb begin
      w_load_data = w_shifted;
      case (r_ld_type)
         LD_B:    w_load_data = {{(DATA_W-8){w_shifted[7]}},   w_shifted[7:0]};
         LD_BU:   w_load_data = {{(DATA_W-8){1'b0}},           w_shifted[7:0]};
         LD_H:    w_load_data = {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
         LD_HU:   w_load_data = {{(DATA_W-16){1'b0}},          w_shifted[15:0]};
         default: w_load_data = w_shifted;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              r_result <= '0;
      else if (w_resp_now && !excep_flush_i) r_result <= w_load_data;
   end

   assign dmem.data_req   = (r_state == S_REQ);
   assign dmem.data_wr    = (r_we != 4'b0000);
   assign dmem.data_wstrb = r_we;
   assign dmem.data_addr  = r_addr;
   assign dmem.data_wdata = r_wdata;

   assign wb_pc_o         = r_pc;
   assign wb_regs_we_o    = r_regs_we;
   assign wb_regs_waddr_o = r_regs_waddr;
   assign wb_regs_wdata_o = w_is_load ? r_result : r_regs_wdata;
   assign wb_excep_en_o   = r_excep_en;

   assign fwd_we_o    = r_valid && r_regs_we && !excep_flush_i;
   assign fwd_waddr_o = r_valid ? r_regs_waddr : '0;
   assign mem_excep_o = r_valid && r_excep_en;

`ifdef MEM_LOAD_FWD_EN
   assign fwd_wdata_o = !r_valid   ? '0 :
                        w_resp_now ? w_load_data : wb_regs_wdata_o;
   assign fwd_busy_o  = r_valid && w_is_load && (r_state != S_DONE) && !w_resp_now;
`else
   assign fwd_wdata_o = r_valid ? wb_regs_wdata_o : '0;
   assign fwd_busy_o  = r_valid && w_is_load && (r_state != S_DONE);
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage: load alignment vectors plus store stall,
// flush/cancel, exception and forwarding-busy sequences.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, allowin, flush, req, regs_we, excep_en, wb_allowin;
   logic [3:0]  we;
   logic [2:0]  ld_type;
   logic [4:0]  regs_waddr;
   logic [31:0] pc, addr, wdata, regs_wdata;
   logic        wb_valid, wb_regs_we, wb_excep_en, fwd_we, fwd_busy, mem_excep;
   logic [31:0] wb_pc, wb_regs_wdata, fwd_wdata;
   logic [4:0]  wb_regs_waddr, fwd_waddr;

   int n_checks = 0;
   int n_errors = 0;

   mem_stage_if #(.DATA_W(32)) dmem ();

   mem_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst(rst),
      .ex_to_mem_valid_i(ex_valid), .mem_allowin_o(allowin), .excep_flush_i(flush),
      .pc_i(pc), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .ld_type_i(ld_type),
      .regs_we_i(regs_we), .regs_waddr_i(regs_waddr), .regs_wdata_i(regs_wdata),
      .excep_en_i(excep_en), .dmem(dmem), .wb_allowin_i(wb_allowin),
      .mem_to_wb_valid_o(wb_valid), .wb_pc_o(wb_pc), .wb_regs_we_o(wb_regs_we),
      .wb_regs_waddr_o(wb_regs_waddr), .wb_regs_wdata_o(wb_regs_wdata),
      .wb_excep_en_o(wb_excep_en), .fwd_we_o(fwd_we), .fwd_waddr_o(fwd_waddr),
      .fwd_wdata_o(fwd_wdata), .fwd_busy_o(fwd_busy), .mem_excep_o(mem_excep)
   );

   always #5 clk = ~clk;

`ifdef MEM_LOAD_FWD_EN
   localparam logic BUSY_IN_RESP = 1'b0;
`else
   localparam logic BUSY_IN_RESP = 1'b1;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  ld_type;
      logic [31:0] rdata;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      ex_valid = 0; req = 0; we = 4'b0; excep_en = 0; flush = 0;
      dmem.data_addr_ok = 0; dmem.data_data_ok = 0; dmem.data_rdata = '0;
   endtask

   // Full load: accept, REQ with addr_ok, WAIT with data_ok, DONE handoff, back to IDLE.
   task automatic run_load(input vec_t v);
      @(negedge clk);
      ex_valid = 1; req = 1; we = 4'b0; addr = v.addr; ld_type = v.ld_type;
      regs_we = 1; regs_waddr = 5'd7; regs_wdata = 32'h1111_2222; pc = 32'h0000_4000;
      #1 check({v.name, " allowin"}, allowin, 1);
      @(negedge clk);
      ex_valid = 0; req = 0; addr = 32'hFFFF_FFFC; dmem.data_addr_ok = 1;
      #1 check({v.name, " req"}, dmem.data_req, 1);
      check({v.name, " req_addr"}, dmem.data_addr, v.addr);
      check({v.name, " req_wr"}, dmem.data_wr, 0);
      check({v.name, " busy_req"}, fwd_busy, 1);
      check({v.name, " wbv_req"}, wb_valid, 0);
      @(negedge clk);
      dmem.data_addr_ok = 0; dmem.data_data_ok = 1; dmem.data_rdata = v.rdata;
      #1 check({v.name, " req_wait"}, dmem.data_req, 0);
      check({v.name, " wbv_wait"}, wb_valid, 0);
      check({v.name, " busy_resp"}, fwd_busy, BUSY_IN_RESP);
`ifdef MEM_LOAD_FWD_EN
      check({v.name, " fwd_resp"}, fwd_wdata, v.exp);
`endif
      @(negedge clk);
      dmem.data_data_ok = 0; dmem.data_rdata = 32'hA5A5_A5A5;
      #1 check({v.name, " wbv_done"}, wb_valid, 1);
      check({v.name, " wdata"}, wb_regs_wdata, v.exp);
      check({v.name, " busy_done"}, fwd_busy, 0);
      check({v.name, " fwd_we"}, fwd_we, 1);
      check({v.name, " fwd_waddr"}, fwd_waddr, 7);
      check({v.name, " fwd_wdata"}, fwd_wdata, v.exp);
      @(negedge clk);
      #1 check({v.name, " wbv_after"}, wb_valid, 0);
      check({v.name, " allowin_after"}, allowin, 1);
   endtask

   initial begin
      vecs[0] = '{32'h0000_0100, 3'd0, 32'h8765_4321, 32'h8765_4321, "ld.w"};
      vecs[1] = '{32'h0000_0103, 3'd1, 32'h8012_3456, 32'hFFFF_FF80, "ld.b_103"};
      vecs[2] = '{32'h0000_0103, 3'd2, 32'h8012_3456, 32'h0000_0080, "ld.bu_103"};
      vecs[3] = '{32'h0000_0102, 3'd3, 32'h8001_1234, 32'hFFFF_8001, "ld.h_102"};
      vecs[4] = '{32'h0000_0102, 3'd4, 32'h8001_1234, 32'h0000_8001, "ld.hu_102"};
      vecs[5] = '{32'h0000_0101, 3'd1, 32'h1234_7F56, 32'h0000_007F, "ld.b_101"};
      vecs[6] = '{32'h0000_0100, 3'd2, 32'hAABB_CCDD, 32'h0000_00DD, "ld.bu_100"};
      vecs[7] = '{32'h0000_0100, 3'd3, 32'h1234_F00F, 32'hFFFF_F00F, "ld.h_100"};
      vecs[8] = '{32'h0000_0102, 3'd1, 32'h00FE_0000, 32'hFFFF_FFFE, "ld.b_102"};

      idle_inputs();
      pc = '0; addr = '0; wdata = '0; ld_type = '0; regs_we = 0; regs_waddr = '0;
      regs_wdata = '0; wb_allowin = 1;
      rst = 1;
      #12;
      check("rst allowin", allowin, 0);
      check("rst data_req", dmem.data_req, 0);
      check("rst wb_valid", wb_valid, 0);
      check("rst fwd_busy", fwd_busy, 0);
      check("rst fwd_we", fwd_we, 0);
      check("rst mem_excep", mem_excep, 0);
      check("rst wb_wdata", wb_regs_wdata, 0);
      check("rst wb_pc", wb_pc, 0);
      @(negedge clk); rst = 0;
      #1 check("post_rst allowin", allowin, 1);

      for (int i = 0; i < 9; i++) run_load(vecs[i]);

      // st.h at 0x102 with addr_ok stalled three cycles.
      @(negedge clk);
      ex_valid = 1; req = 1; we = 4'b1100; addr = 32'h0000_0102; wdata = 32'hBEEF_BEEF;
      regs_we = 0; regs_wdata = 32'h5555_AAAA;
      #1 check("st allowin", allowin, 1);
      @(negedge clk);
      ex_valid = 0; req = 0; we = 4'b0; addr = 32'hFFFF_FFF0; wdata = '0;
      for (int i = 0; i < 3; i++) begin
         #1 check("st stall req", dmem.data_req, 1);
         check("st stall addr", dmem.data_addr, 32'h0000_0102);
         check("st stall wstrb", dmem.data_wstrb, 4'b1100);
         check("st stall wdata", dmem.data_wdata, 32'hBEEF_BEEF);
         check("st stall wr", dmem.data_wr, 1);
         check("st stall allowin", allowin, 0);
         @(negedge clk);
      end
      dmem.data_addr_ok = 1;
      #1 check("st addr_ok req", dmem.data_req, 1);
      @(negedge clk);
      dmem.data_addr_ok = 0; dmem.data_data_ok = 1;
      #1 check("st wait allowin", allowin, 0);
      check("st wait wbv", wb_valid, 0);
      @(negedge clk);
      dmem.data_data_ok = 0;
      #1 check("st done wbv", wb_valid, 1);
      check("st done regs_we", wb_regs_we, 0);
      check("st done wdata", wb_regs_wdata, 32'h5555_AAAA);
      check("st done busy", fwd_busy, 0);
      @(negedge clk);
      #1 check("st after wbv", wb_valid, 0);

      // Flush in WAIT, response two cycles later is discarded via CANCEL.
      @(negedge clk);
      ex_valid = 1; req = 1; we = 4'b0; addr = 32'h0000_0104; ld_type = 3'd0; regs_we = 1;
      @(negedge clk);
      ex_valid = 0; req = 0; dmem.data_addr_ok = 1;
      @(negedge clk);
      dmem.data_addr_ok = 0; flush = 1;
      #1 check("fw flush wbv", wb_valid, 0);
      @(negedge clk);
      flush = 0;
      #1 check("fw cancel allowin", allowin, 0);
      check("fw cancel wbv", wb_valid, 0);
      check("fw cancel fwd_we", fwd_we, 0);
      check("fw cancel busy", fwd_busy, 0);
      @(negedge clk);
      dmem.data_data_ok = 1; dmem.data_rdata = 32'h1234_5678;
      #1 check("fw dataok allowin", allowin, 0);
      check("fw dataok wbv", wb_valid, 0);
      @(negedge clk);
      dmem.data_data_ok = 0; dmem.data_rdata = '0;
      #1 check("fw idle allowin", allowin, 1);
      check("fw idle wbv", wb_valid, 0);
      check("fw idle req", dmem.data_req, 0);

      // Flush in REQ without addr_ok drops the request.
      @(negedge clk);
      ex_valid = 1; req = 1; addr = 32'h0000_0200;
      @(negedge clk);
      ex_valid = 0; req = 0; flush = 1;
      #1 check("fr flush req", dmem.data_req, 1);
      @(negedge clk);
      flush = 0;
      #1 check("fr after req", dmem.data_req, 0);
      check("fr after allowin", allowin, 1);
      check("fr after wbv", wb_valid, 0);

      // Excepting load: no request, handoff next cycle with the exception flag.
      @(negedge clk);
      ex_valid = 1; req = 1; we = 4'b0; excep_en = 1; addr = 32'h0000_0108; regs_we = 0;
      pc = 32'h0000_5008;
      @(negedge clk);
      ex_valid = 0; req = 0; excep_en = 0;
      #1 check("ex data_req", dmem.data_req, 0);
      check("ex mem_excep", mem_excep, 1);
      check("ex wbv", wb_valid, 1);
      check("ex wb_excep", wb_excep_en, 1);
      check("ex wb_pc", wb_pc, 32'h0000_5008);
      check("ex busy", fwd_busy, 0);
      @(negedge clk);
      #1 check("ex after excep", mem_excep, 0);
      check("ex after wbv", wb_valid, 0);
      check("ex after req", dmem.data_req, 0);

      run_load(vecs[0]);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly downstream of the execute stage. It latches the execute-stage bundle into its own pipeline register and issues the data-memory request over a req/addr_ok/data_ok handshake. It waits for the response, aligns and extends load data, and hands the result to write-back. It also provides register forwarding and busy/exception status back to the decode and execute stages.

## Interface
- DATA_W, 32, data and address width
- REG_AW, 5, register-file address width
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ex_to_mem_valid_i  in  1  execute stage presents a valid instruction
- mem_allowin_o  out  1  this stage accepts a new instruction this cycle
- excep_flush_i  in  1  write-back exception flush
- pc_i  in  DATA_W  instruction PC
- req_i  in  1  instruction accesses memory
- we_i  in  4  byte write strobes; 0 means load
- addr_i  in  DATA_W  access address
- wdata_i  in  DATA_W  store data, already lane-replicated
- ld_type_i  in  3  0 = word, 1 = byte signed, 2 = byte unsigned, 3 = half signed, 4 = half unsigned
- regs_we_i / regs_waddr_i / regs_wdata_i  in  1 / REG_AW / DATA_W  register write info
- excep_en_i  in  1  instruction carries an exception
- data_req_o, data_wr_o, data_wstrb_o[3:0], data_addr_o, data_wdata_o  out  data-memory request
- data_addr_ok_i, data_data_ok_i  in  1  request accepted / response valid
- data_rdata_i  in  DATA_W  read data
- wb_allowin_i  in  1  write-back stage accepts
- mem_to_wb_valid_o  out  1  result valid to write-back
- wb_pc_o, wb_regs_we_o, wb_regs_waddr_o, wb_regs_wdata_o, wb_excep_en_o  out  write-back bundle
- fwd_we_o, fwd_waddr_o, fwd_wdata_o  out  forwarding to decode
- fwd_busy_o  out  1  load result not yet available; decode must stall on a match
- mem_excep_o  out  1  stage holds a valid excepting instruction; drives the execute stage's memory stall

## Operation
- Pipeline register loads on ex_to_mem_valid_i && mem_allowin_o. valid clears on excep_flush_i and on handoff without a new accept.
- FSM states: IDLE, REQ, WAIT, DONE, CANCEL.
- IDLE → REQ on accept when req_i && !excep_en_i.
- Non-memory and excepting instructions stay in IDLE with ready_go = 1. No request is ever issued for an excepting instruction.
- REQ: data_req_o = 1 with address, strobes, data and wr = (we_i != 0) held stable. On data_addr_ok_i → WAIT.
- WAIT: on data_data_ok_i, capture the aligned load result into the result register → DONE.
- DONE: ready_go = 1. On handoff → REQ if a new memory instruction is accepted the same cycle, otherwise IDLE.
- Load alignment: shift data_rdata_i right by 8 × addr[1:0], then zero- or sign-extend per ld_type. Stores write regs_wdata_i unchanged.
- mem_allowin_o = !valid || (ready_go && wb_allowin_i). It is forced to 0 in CANCEL.
- fwd_* mirror the wb_* fields when valid. fwd_busy_o = valid && load && state != DONE.
- mem_excep_o = valid && excep_en.

## Timing
- Reset: every output 0, state IDLE, valid 0, result register 0.
- Minimum load latency: 1 cycle REQ + 1 cycle WAIT + DONE. Handoff to write-back in the cycle after data_ok.
- data_data_ok_i is ignored outside WAIT and CANCEL. The memory returns data_ok no earlier than the cycle after addr_ok.
- Flush in REQ without addr_ok: drop the request, → IDLE next cycle.
- Flush coincident with addr_ok in REQ, or flush in WAIT: → CANCEL. Stay in CANCEL, allowin 0, until data_ok, then → IDLE. The response is discarded.
- Flush in IDLE or DONE: valid clears next cycle and nothing is forwarded.
- Reset mid-transaction clears all state immediately. An outstanding response after reset is the memory's responsibility.

## Configuration
- MEM_LOAD_FWD_EN defined:
  - In WAIT with data_data_ok_i, fwd_wdata_o carries the aligned data_rdata_i combinationally.
  - fwd_busy_o drops in that same cycle.
- MEM_LOAD_FWD_EN undefined:
  - fwd_busy_o stays high until DONE.
  - fwd_wdata_o is sourced only from the result register.

## Test plan
- ld.w at 0x100, addr_ok in the REQ cycle, data_ok one cycle later with 0x8765_4321 → wb_regs_wdata_o = 0x8765_4321 and mem_to_wb_valid_o high exactly once.
- ld.b at 0x103 with rdata 0x80xx_xxxx → 0xFFFF_FF80. Repeat as ld.bu → 0x0000_0080. ld.h at 0x102 with rdata 0x8001_xxxx → 0xFFFF_8001.
- st.h at 0x102 with strobes 4'b1100, addr_ok stalled 3 cycles → data_req_o held high with stable fields for 3 cycles, mem_allowin_o 0 throughout.
- Flush while in WAIT, data_ok 2 cycles later → CANCEL, no write-back valid, mem_allowin_o low until data_ok, IDLE after.
- Excepting instruction enters → no data_req_o, mem_excep_o = 1, handoff next cycle with wb_excep_en_o = 1.
- Load in WAIT with matching decode read → fwd_busy_o drops in the data_ok cycle with MEM_LOAD_FWD_EN defined, and one cycle later without it.
